// File: rtl/fib_req_sched.sv
// Round-robin scheduler sharing one Fibonacci core between NUM_REQ requesters.
// Handshake: a requester holds req/req_n until its one-cycle ack; the result returns later on a one-cycle resp_valid pulse.
module fib_req_sched #(
   parameter int NUM_REQ      = 4,
   parameter int INPUT_WIDTH  = 6,
   parameter int OUTPUT_WIDTH = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_n,
   output logic [NUM_REQ-1:0]             ack,
   output logic [NUM_REQ-1:0]             resp_valid,
   output logic [OUTPUT_WIDTH-1:0]        resp_result,
   output logic                           resp_overflow,
   output logic                           busy,
   output logic                           fib_go,
   output logic [INPUT_WIDTH-1:0]         fib_n,
   input  logic [OUTPUT_WIDTH-1:0]        fib_result,
   input  logic                           fib_overflow,
   input  logic                           fib_done,
   output logic [2:0]                     dbg_state
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_CLR  = 3'd2,
      WAIT_DONE = 3'd3,
      RESP      = 3'd4
   } state_t;

   state_t                 state, state_nx;
   logic [IDX_W-1:0]       rr_ptr, grant_idx, pick_idx;
   logic                   pick_valid;
   logic [INPUT_WIDTH-1:0] n_lat;

   assign fib_n     = n_lat;
   assign dbg_state = state;

   // First set request at or above rr_ptr, wrapping around.
   always_comb begin
      int cand;
      cand       = 0;
      pick_valid = 1'b0;
      pick_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = int'(rr_ptr) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!pick_valid && req[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = IDX_W'(cand);
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (pick_valid) state_nx = ISSUE;
         ISSUE:     state_nx = WAIT_CLR;
         WAIT_CLR:  if (!fib_done) state_nx = WAIT_DONE;
         WAIT_DONE: if (fib_done) state_nx = RESP;
         RESP:      state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         rr_ptr        <= '0;
         grant_idx     <= '0;
         n_lat         <= '0;
         ack           <= '0;
         resp_valid    <= '0;
         resp_result   <= '0;
         resp_overflow <= 1'b0;
         busy          <= 1'b0;
         fib_go        <= 1'b0;
      end else begin
         state      <= state_nx;
         fib_go     <= (state_nx == ISSUE);
         busy       <= (state_nx != IDLE);
         ack        <= '0;
         resp_valid <= '0;
         if (state == IDLE && pick_valid) begin
            grant_idx <= pick_idx;
            n_lat     <= req_n[pick_idx*INPUT_WIDTH +: INPUT_WIDTH];
            ack       <= ONE_HOT0 << pick_idx;
         end
         if (state == WAIT_DONE && fib_done) begin
            resp_result   <= fib_result;
            resp_overflow <= fib_overflow;
            resp_valid    <= ONE_HOT0 << grant_idx;
         end
         if (state == RESP) begin
            if (int'(grant_idx) == NUM_REQ - 1) rr_ptr <= '0;
            else                                 rr_ptr <= grant_idx + 1'b1;
         end
      end
   end

endmodule
